// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// uart_cmd_parser : assembles 7-byte checksummed UART frames into DDS config
// Rev 1.0
// ============================================================================
module uart_cmd_parser #(
  parameter int SYS_CLK_FRE  = 50_000_000,
  parameter int TIMEOUT_CLKS = (SYS_CLK_FRE / 9600) * 20,
  parameter int TO_W         = 20
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [31:0] freq_word,
  output logic [11:0] phase_word,
  output logic [1:0]  wave_sel,
  output logic [7:0]  amp_word,
  output logic        cfg_update,
  output logic        chk_err,
  output logic        cmd_err,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_CHK  = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]      SYNC    = 8'h55;

  state_t          state, state_nx;
  logic            rx_valid_d;
  logic            accept;
  logic            to_hit;
  logic            sum_ok;
  logic [7:0]      cmd;
  logic [7:0]      sum;
  logic [31:0]     shreg;
  logic [1:0]      byte_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            upd_nx, chk_nx, cmderr_nx, to_nx;

  // A byte is taken only on the rising edge of the valid level.
  assign accept = rx_valid & ~rx_valid_d;
  assign to_hit = (state != ST_IDLE) && !accept && (to_cnt == TO_LAST);
  assign sum_ok = (rx_data == sum);

  always_comb begin
    state_nx  = state;
    upd_nx    = 1'b0;
    chk_nx    = 1'b0;
    cmderr_nx = 1'b0;
    to_nx     = 1'b0;
    if (to_hit) begin
      state_nx = ST_IDLE;
      to_nx    = 1'b1;
    end else if (accept) begin
      case (state)
        ST_IDLE: if (rx_data == SYNC) state_nx = ST_CMD;
        ST_CMD:  state_nx = ST_DATA;
        ST_DATA: if (byte_cnt == 2'd3) state_nx = ST_CHK;
        ST_CHK: begin
          state_nx = ST_IDLE;
          if (!sum_ok)
            chk_nx = 1'b1;
          else if (cmd >= 8'h01 && cmd <= 8'h04)
            upd_nx = 1'b1;
          else
            cmderr_nx = 1'b1;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      rx_valid_d  <= 1'b0;
      cmd         <= 8'h00;
      sum         <= 8'h00;
      shreg       <= 32'h0;
      byte_cnt    <= 2'd0;
      to_cnt      <= '0;
      freq_word   <= 32'h0;
      phase_word  <= 12'h0;
      wave_sel    <= 2'd0;
      amp_word    <= 8'hFF;
      cfg_update  <= 1'b0;
      chk_err     <= 1'b0;
      cmd_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      rx_valid_d  <= rx_valid;
      cfg_update  <= upd_nx;
      chk_err     <= chk_nx;
      cmd_err     <= cmderr_nx;
      timeout_err <= to_nx;

      if (state == ST_IDLE || accept || to_hit)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + TO_W'(1);

      if (accept) begin
        case (state)
          ST_CMD: begin
            cmd      <= rx_data;
            sum      <= rx_data;
            byte_cnt <= 2'd0;
          end
          ST_DATA: begin
            shreg    <= {shreg[23:0], rx_data};
            sum      <= sum + rx_data;
            byte_cnt <= byte_cnt + 2'd1;
          end
          default: ;
        endcase
      end

      // Shift register holds the complete payload by the time CHK is accepted.
      if (upd_nx) begin
        case (cmd)
          8'h01:   freq_word  <= shreg;
          8'h02:   phase_word <= shreg[11:0];
          8'h03:   wave_sel   <= shreg[1:0];
          8'h04:   amp_word   <= shreg[7:0];
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// tb_uart_cmd_parser : directed + random frames against a queue-based model
// Rev 1.0
// ============================================================================
module tb_uart_cmd_parser;

  localparam int T = 1000;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        rx_valid  = 1'b0;
  logic [7:0]  rx_data   = 8'h00;
  logic [31:0] freq_word;
  logic [11:0] phase_word;
  logic [1:0]  wave_sel;
  logic [7:0]  amp_word;
  logic        cfg_update, chk_err, cmd_err, timeout_err;
  logic [3:0]  pulses;

  assign pulses = {cfg_update, chk_err, cmd_err, timeout_err};

  uart_cmd_parser #(
    .SYS_CLK_FRE (50_000_000),
    .TIMEOUT_CLKS(T),
    .TO_W        (10)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .freq_word  (freq_word),
    .phase_word (phase_word),
    .wave_sel   (wave_sel),
    .amp_word   (amp_word),
    .cfg_update (cfg_update),
    .chk_err    (chk_err),
    .cmd_err    (cmd_err),
    .timeout_err(timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] e_freq  = 32'h0;
  logic [11:0] e_phase = 12'h0;
  logic [1:0]  e_wave  = 2'd0;
  logic [7:0]  e_amp   = 8'hFF;
  logic [7:0]  frame[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_regs(input string tag);
    check_eq({tag, "_freq"},  freq_word,  e_freq);
    check_eq({tag, "_phase"}, phase_word, e_phase);
    check_eq({tag, "_wave"},  wave_sel,   e_wave);
    check_eq({tag, "_amp"},   amp_word,   e_amp);
  endtask

  // Frame-level reference: returns {update, chk_err, cmd_err, timeout} expected next cycle.
  function automatic logic [3:0] model_byte(input logic [7:0] b);
    logic [7:0]  s;
    logic [31:0] d;
    logic [3:0]  p;
    p = 4'b0000;
    if (frame.size() == 0) begin
      if (b == 8'h55) frame.push_back(b);
      return p;
    end
    frame.push_back(b);
    if (frame.size() == 7) begin
      s = frame[1] + frame[2] + frame[3] + frame[4] + frame[5];
      d = {frame[2], frame[3], frame[4], frame[5]};
      if (s != frame[6]) p = 4'b0100;
      else begin
        case (frame[1])
          8'h01:   begin e_freq  = d;        p = 4'b1000; end
          8'h02:   begin e_phase = d[11:0];  p = 4'b1000; end
          8'h03:   begin e_wave  = d[1:0];   p = 4'b1000; end
          8'h04:   begin e_amp   = d[7:0];   p = 4'b1000; end
          default: p = 4'b0010;
        endcase
      end
      frame.delete();
    end
    return p;
  endfunction

  // Entered #1 after a posedge; valid high for 'hold' cycles, then low 'gap' cycles (gap >= 1).
  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    logic [3:0] ep;
    ep       = model_byte(b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge sys_clk); #1;
    if (hold <= 1) rx_valid = 1'b0;
    check_eq("pulse_after_byte", {28'h0, pulses}, {28'h0, ep});
    check_regs("regs_after_byte");
    for (int c = 2; c <= hold + gap; c++) begin
      @(posedge sys_clk); #1;
      if (c == hold) rx_valid = 1'b0;
      if (frame.size() != 0 && c == T + 1) begin
        ep = 4'b0001;
        frame.delete();
      end else begin
        ep = 4'b0000;
      end
      check_eq("pulse_idle", {28'h0, pulses}, {28'h0, ep});
    end
  endtask

  task automatic send_frame(input logic [55:0] f, input int hold, input int gap);
    for (int i = 6; i >= 0; i--) send_byte(f[i*8 +: 8], hold, gap);
  endtask

  function automatic logic [55:0] make_frame(input logic [7:0] cmd, input logic [31:0] d);
    logic [7:0] chk;
    chk = cmd + d[31:24] + d[23:16] + d[15:8] + d[7:0];
    return {8'h55, cmd, d, chk};
  endfunction

  initial begin
    #(90_000 * 10);
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  cmd, g;
    logic [55:0] f;

    repeat (3) @(posedge sys_clk);
    #1;
    check_regs("reset");
    check_eq("reset_pulses", {28'h0, pulses}, 32'h0);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    send_frame(56'h55_01_00_00_10_00_11, 1, 2);
    check_eq("freq_0x1000", freq_word, 32'h0000_1000);

    send_frame(56'h55_02_00_00_04_00_06, 2, 1);
    send_frame(56'h55_03_00_00_00_02_05, 1, 1);
    send_frame(56'h55_04_00_00_00_80_84, 3, 2);
    check_eq("phase_0x400", phase_word, 32'h400);
    check_eq("wave_2",      wave_sel,   32'h2);
    check_eq("amp_0x80",    amp_word,   32'h80);

    send_frame(56'h55_01_12_34_56_78_00, 1, 1);
    send_frame(56'h55_07_00_00_00_01_08, 1, 1);

    send_byte(8'hAA, 300, 3);
    send_byte(8'h13, 300, 3);
    send_frame(56'h55_01_00_00_00_05_06, 300, 3);
    check_eq("freq_5", freq_word, 32'h5);

    // Abandoned frame: last byte followed by a full timeout window.
    send_byte(8'h55, 1, 1);
    send_byte(8'h01, 1, 1);
    send_byte(8'h00, 1, T);
    send_frame(make_frame(8'h01, 32'hCAFE_0001), 1, 1);

    // Gaps just under the limit, and a byte landing on the last counter value.
    send_byte(8'h55, 1, 1);
    send_byte(8'h01, 1, T - 2);
    send_byte(8'h00, 1, T - 1);
    send_byte(8'h00, 1, 1);
    send_byte(8'h12, 1, 1);
    send_byte(8'h34, 1, 1);
    send_byte(8'h47, 1, 1);
    check_eq("freq_no_timeout", freq_word, 32'h0000_1234);

    // Asynchronous reset in the middle of a frame.
    send_byte(8'h55, 1, 1);
    send_byte(8'h01, 1, 1);
    send_byte(8'h00, 1, 1);
    send_byte(8'h00, 1, 1);
    #3 sys_rst_n = 1'b0;
    #1;
    e_freq = 32'h0; e_phase = 12'h0; e_wave = 2'd0; e_amp = 8'hFF;
    frame.delete();
    check_regs("async_reset");
    check_eq("async_reset_pulses", {28'h0, pulses}, 32'h0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    send_frame(make_frame(8'h03, 32'h0000_0003), 1, 1);
    check_eq("wave_after_reset", wave_sel, 32'h3);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'h55) g = 8'h56;
        send_byte(g, $urandom_range(1, 8), $urandom_range(1, 8));
      end
      case ($urandom_range(0, 9))
        0, 1:    cmd = 8'h01;
        2, 3:    cmd = 8'h02;
        4, 5:    cmd = 8'h03;
        6, 7:    cmd = 8'h04;
        8:       cmd = 8'h00;
        default: cmd = 8'($urandom_range(5, 255));
      endcase
      d = $urandom;
      if (n == 5) d[15:8] = 8'h55;
      f = make_frame(cmd, d);
      if ($urandom_range(0, 4) == 0) f[7:0] = f[7:0] ^ 8'($urandom_range(1, 255));
      send_frame(f, $urandom_range(1, 8), $urandom_range(1, 8));
    end
    check_regs("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Byte-level command parser placed directly downstream of the UART receiver. Consumes received bytes, assembles fixed-length checksummed frames and writes the decoded DDS configuration registers: frequency word, phase word, waveform select and amplitude. Issues a one-cycle update strobe to the DDS core per accepted frame, plus error pulses for a status LED or counter.

Parameters:
SYS_CLK_FRE, 50_000_000, system clock frequency in Hz (documentation only; sizes the default timeout)
TIMEOUT_CLKS, 104_160, maximum idle gap in clocks between two bytes of one frame (about 2 characters at 9600 bps)
TO_W, 20, timeout counter width; must hold TIMEOUT_CLKS

Ports:
sys_clk  input  1  system clock
sys_rst_n  input  1  asynchronous, active-low reset
rx_valid  input  1  receiver byte-valid level; may stay high for many cycles per byte
rx_data  input  8  received byte; stable while rx_valid=1
freq_word  output  32  DDS frequency tuning word
phase_word  output  12  DDS phase offset
wave_sel  output  2  waveform select (0 sine, 1 triangle, 2 square, 3 saw)
amp_word  output  8  amplitude scale
cfg_update  output  1  one-cycle pulse: a configuration register was written
chk_err  output  1  one-cycle pulse: checksum mismatch
cmd_err  output  1  one-cycle pulse: valid checksum, unknown command
timeout_err  output  1  one-cycle pulse: frame abandoned on inter-byte timeout

Behaviour:
- Reset (async, sys_rst_n=0): freq_word=0, phase_word=0, wave_sel=0, amp_word=8'hFF. All pulses=0. FSM=IDLE. Counters=0. rx_valid_d=0.
- Byte accept: register rx_valid into rx_valid_d. A byte is accepted in the cycle where rx_valid=1 and rx_valid_d=0. A valid level held for N cycles yields exactly one byte.
- Frame format: 0x55, CMD, D3, D2, D1, D0, CHK. Data is big-endian. CHK = (CMD+D3+D2+D1+D0) mod 256.
- FSM states: IDLE, CMD, DATA, CHK.
  - IDLE: accepted 0x55 goes to CMD. Any other byte is discarded silently, with no error.
  - CMD: latch the byte as the command and go to DATA. Clear the data byte counter to 0.
  - DATA: shift the byte into a 32-bit shift register. The counter counts 0..3. After the 4th byte, go to CHK.
  - CHK: compare the byte against the running 8-bit sum. Always return to IDLE afterwards.
  - 0x55 has no special meaning outside IDLE; there is no mid-frame resync.
- Checksum byte accepted with a match:
  - CMD 0x01: freq_word = data[31:0].
  - CMD 0x02: phase_word = data[11:0].
  - CMD 0x03: wave_sel = data[1:0].
  - CMD 0x04: amp_word = data[7:0].
  - For 0x01–0x04, the register and cfg_update=1 both take effect in the cycle after the accept cycle (latency 1).
  - Any other CMD: cmd_err=1 in that same cycle, no register change.
- Checksum mismatch: chk_err=1 in the cycle after accept. No register changes.
- Timeout: a counter runs in every state except IDLE. It clears to 0 on each accepted byte and is held at 0 in IDLE. When it reaches TIMEOUT_CLKS-1 with no byte accepted, the FSM goes to IDLE and timeout_err=1 for one cycle. If a byte is accepted in that same cycle, the byte wins: the counter clears and there is no timeout.
- Pulses are mutually exclusive and each lasts exactly one cycle.
- Configuration outputs hold their value between frames.
- Reset mid-frame discards the partial frame with no pulse. The first byte after reset release must be 0x55 to start a frame.

Test Plan:
- Reset sequence, then frame 55 01 00 00 10 00 11 -> freq_word=0x00001000. cfg_update high exactly 1 cycle, 1 clk after the CHK byte edge. No error pulses.
- Frames 55 02 00 00 04 00 06, then 55 03 00 00 00 02 05, then 55 04 00 00 00 80 84 -> phase_word=0x400, wave_sel=2, amp_word=0x80. 3 cfg_update pulses. freq_word unchanged.
- Frame 55 01 12 34 56 78 00 (correct CHK is 0x15) -> chk_err 1 cycle, freq_word unchanged. Then frame 55 07 00 00 00 01 08 -> cmd_err 1 cycle, no register change.
- Garbage AA 13 before 55 01 00 00 00 05 06, with rx_valid held 300 cycles per byte -> garbage ignored. Each byte counted once. freq_word=5.
- Send 55 01 00, then idle TIMEOUT_CLKS cycles -> timeout_err 1 cycle, FSM in IDLE. A following full valid frame is accepted normally. A gap of TIMEOUT_CLKS-2 cycles -> no timeout.
- Assert sys_rst_n=0 asynchronously after 55 01 00 00 -> all outputs at reset values immediately. A following complete valid frame decodes correctly.
